rmii_rx_deframer: RTL and testbench



---
 rtl/rmii_pkg.sv | 27 ++
 rtl/rmii_crc32.sv | 41 ++++
 rtl/rmii_rx_deframer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rmii_rx_deframer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_pkg.sv
// rtl/rmii_pkg.sv - shared types and constants for the RMII receive deframer
package rmii_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    // Bit-reverse a 32-bit word; links the LSB-first CRC register to the MSB-first constants.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rmii_crc32.sv
// rtl/rmii_crc32.sv - byte-wide reflected CRC-32 register with clear and enable
module rmii_crc32
    import rmii_pkg::*;
(
    input  logic        clk_rmii,
    input  logic        rst_ni,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    // The register shifts right (LSB first), so it works with the reflected polynomial.
    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    logic [31:0] crc_next;

    // Fold one byte into the CRC, earliest wire bit (bit 0) first.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0] ^ data[i]) begin
                crc_next = (crc_next >> 1) ^ POLY_REFL;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

    // CRC state: restart on clear, advance on each completed byte.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/rmii_rx_deframer.sv
// rtl/rmii_rx_deframer.sv - RMII dibit receiver: preamble/SFD strip, byte assembly, framing; FCS check under RMII_RX_FCS_CHECK_EN
module rmii_rx_deframer
    import rmii_pkg::*;
#(
    parameter int MAX_FRAME    = 1522,
    parameter int MIN_PREAMBLE = 4,
    parameter int LEN_W        = 11,
    parameter int CNT_W        = 16
) (
    input  logic             clk_rmii,
    input  logic             rst_ni,
    input  logic [1:0]       rmii_rxd,
    input  logic             rmii_crs_dv,
    input  logic             rmii_rx_er,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sop,
    output logic             rx_eop,
    output logic             rx_err,
    output logic [LEN_W-1:0] rx_len,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef RMII_RX_FCS_CHECK_EN
    ,
    output logic             fcs_err
`endif
);

    localparam int               PRE_W   = $clog2(MIN_PREAMBLE + 1);
    localparam logic [PRE_W-1:0] PRE_SAT = PRE_W'(MIN_PREAMBLE);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);

    logic [1:0]       d_q;
    logic             dv_q;
    logic             er_q;

    rx_state_e        state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [5:0]       sh_q, sh_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic             first_q, first_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             bad_q, bad_d;

    logic [7:0]       data_d;
    logic             valid_d, sop_d, eop_d, err_d;
    logic [LEN_W-1:0] len_out_d;
    logic             good_inc, bad_inc;

    logic             end_now;
    logic [LEN_W-1:0] held_len;
    logic             fcs_bad;

    // Carrier drop only counts on nibble boundaries; odd-index drops are CRS toggling.
    assign end_now  = (state_q == DATA) && !dv_q && !idx_q[0];
    assign held_len = len_q + LEN_W'(1);

`ifdef RMII_RX_FCS_CHECK_EN
    logic [31:0] crc_val;

    rmii_crc32 u_crc (
        .clk_rmii (clk_rmii),
        .rst_ni   (rst_ni),
        .clr      (state_q != DATA),
        .en       ((state_q == DATA) && (idx_q == 2'd3)),
        .data     ({d_q, sh_q}),
        .crc      (crc_val)
    );

    assign fcs_bad = (reflect32(crc_val) != CRC_RESIDUE);

    // FCS failure flag travels with the eop strobe.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            fcs_err <= 1'b0;
        end else begin
            fcs_err <= eop_d && fcs_bad;
        end
    end
`else
    assign fcs_bad = 1'b0;
`endif

    // Register the PHY pins once; all decisions use these copies.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q  <= 2'b00;
            dv_q <= 1'b0;
            er_q <= 1'b0;
        end else begin
            d_q  <= rmii_rxd;
            dv_q <= rmii_crs_dv;
            er_q <= rmii_rx_er;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath updates and the next output strobe.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        first_d   = first_q;
        len_d     = len_q;
        bad_d     = bad_q;
        data_d    = 8'h00;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        err_d     = 1'b0;
        len_out_d = '0;
        good_inc  = 1'b0;
        bad_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dv_q && d_q == PREAMBLE_DIBIT) begin
                    state_d = PREAMBLE;
                    pre_d   = PRE_W'(1);
                end
            end

            PREAMBLE: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end else if (d_q == PREAMBLE_DIBIT) begin
                    if (pre_q < PRE_SAT) begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end else if (d_q == SFD_DIBIT && pre_q >= PRE_SAT) begin
                    state_d  = DATA;
                    idx_d    = 2'd0;
                    sh_d     = 6'd0;
                    len_d    = '0;
                    hold_v_d = 1'b0;
                    first_d  = 1'b1;
                    bad_d    = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end

            DATA: begin
                if (end_now) begin
                    state_d = IDLE;
                    if (hold_v_q) begin
                        valid_d   = 1'b1;
                        data_d    = hold_q;
                        sop_d     = first_q;
                        eop_d     = 1'b1;
                        err_d     = bad_q || er_q || idx_q[1] || fcs_bad;
                        len_out_d = held_len;
                        hold_v_d  = 1'b0;
                        good_inc  = !err_d;
                        bad_inc   = err_d;
                    end else begin
                        bad_inc = 1'b1;
                    end
                end else begin
                    if (er_q) begin
                        bad_d = 1'b1;
                    end
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: sh_d[1:0] = d_q;
                        2'd1: sh_d[3:2] = d_q;
                        2'd2: begin
                            sh_d[5:4] = d_q;
                            // Release the held byte only once the next byte is past its
                            // first nibble, so an odd-nibble end can still flag it.
                            if (hold_v_q) begin
                                valid_d  = 1'b1;
                                data_d   = hold_q;
                                sop_d    = first_q;
                                first_d  = 1'b0;
                                hold_v_d = 1'b0;
                                len_d    = held_len;
                                if (held_len == LEN_MAX) begin
                                    eop_d     = 1'b1;
                                    err_d     = 1'b1;
                                    len_out_d = held_len;
                                    bad_inc   = 1'b1;
                                    state_d   = DROP;
                                end
                            end
                        end
                        default: begin
                            hold_d   = {d_q, sh_q};
                            hold_v_d = 1'b1;
                        end
                    endcase
                end
            end

            DROP: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Byte assembly, holding register and per-frame bookkeeping.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q    <= '0;
            idx_q    <= 2'd0;
            sh_q     <= 6'd0;
            hold_q   <= 8'h00;
            hold_v_q <= 1'b0;
            first_q  <= 1'b0;
            len_q    <= '0;
            bad_q    <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            first_q  <= first_d;
            len_q    <= len_d;
            bad_q    <= bad_d;
        end
    end

    // Registered byte-stream outputs.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            rx_err   <= 1'b0;
            rx_len   <= '0;
        end else begin
            rx_data  <= data_d;
            rx_valid <= valid_d;
            rx_sop   <= sop_d;
            rx_eop   <= eop_d;
            rx_err   <= err_d;
            rx_len   <= len_out_d;
        end
    end

    // Saturating good/bad frame statistics.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (good_inc && frame_cnt != {CNT_W{1'b1}}) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (bad_inc && err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// tb/tb_rmii_rx_deframer.sv - randomized scoreboard bench for rmii_rx_deframer
module tb_rmii_rx_deframer;

    localparam int MAX_FRAME = 1522;
    localparam int MIN_PRE   = 4;

    logic        clk_rmii = 1'b0;
    logic        rst_ni   = 1'b0;
    logic [1:0]  rmii_rxd = 2'b00;
    logic        rmii_crs_dv = 1'b0;
    logic        rmii_rx_er  = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, rx_err;
    logic [10:0] rx_len;
    logic [15:0] frame_cnt, err_cnt;
`ifdef RMII_RX_FCS_CHECK_EN
    logic        fcs_err;
`endif

    rmii_rx_deframer dut (
        .clk_rmii    (clk_rmii),
        .rst_ni      (rst_ni),
        .rmii_rxd    (rmii_rxd),
        .rmii_crs_dv (rmii_crs_dv),
        .rmii_rx_er  (rmii_rx_er),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .rx_err      (rx_err),
        .rx_len      (rx_len),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`ifdef RMII_RX_FCS_CHECK_EN
        ,
        .fcs_err     (fcs_err)
`endif
    );

    always #10 clk_rmii = ~clk_rmii;

    typedef struct {
        logic [7:0] data;
        bit         sop;
        bit         eop;
        bit         err;
        int         len;
        bit         fcs;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fb[$];
    int         total = 0;
    int         bad = 0;
    int         exp_frames = 0;
    int         exp_errs = 0;
    int         strobe_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fb[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic bit fcs_ok(input int n);
        logic [31:0] c;
        if (n < 4) return 1'b0;
        c = ~crc_of(n - 4);
        return {fb[n-1], fb[n-2], fb[n-3], fb[n-4]} == c;
    endfunction

    task automatic append_fcs();
        logic [31:0] c;
        c = ~crc_of(fb.size());
        fb.push_back(c[7:0]);
        fb.push_back(c[15:8]);
        fb.push_back(c[23:16]);
        fb.push_back(c[31:24]);
    endtask

    // Reference model: what a frame built from fb should produce on the byte stream.
    task automatic model_frame(input int pre, input bit odd, input int er_pos);
        int n, m;
        bit ovf, fcsb, err;
        exp_t e;
        if (pre < MIN_PRE) return;
        n = fb.size();
        if (n == 0) begin
            if (exp_errs < 65535) exp_errs++;
            return;
        end
        ovf = n > MAX_FRAME;
        m = ovf ? MAX_FRAME : n;
`ifdef RMII_RX_FCS_CHECK_EN
        fcsb = !fcs_ok(m);
`else
        fcsb = 1'b0;
`endif
        err = ovf || (er_pos >= 0 && er_pos < 4 * n) || odd || fcsb;
        for (int i = 0; i < m; i++) begin
            e.data = fb[i];
            e.sop  = (i == 0);
            e.eop  = (i == m - 1);
            e.err  = (i == m - 1) && err;
            e.len  = (i == m - 1) ? m : 0;
            e.fcs  = (i == m - 1) && fcsb;
            exp_q.push_back(e);
        end
        if (err) begin
            if (exp_errs < 65535) exp_errs++;
        end else begin
            if (exp_frames < 65535) exp_frames++;
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic dv, input logic er);
        @(posedge clk_rmii);
        #2;
        rmii_rxd    = d;
        rmii_crs_dv = dv;
        rmii_rx_er  = er;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk_rmii);
            k++;
        end
        @(negedge clk_rmii);
        check({name, " drained"}, exp_q.size(), 0);
        check({name, " frame_cnt"}, frame_cnt, exp_frames);
        check({name, " err_cnt"}, err_cnt, exp_errs);
    endtask

    task automatic send_frame(input string name, input int pre, input bit odd,
                              input int er_pos, input bit toggle);
        int n;
        logic [7:0] b;
        logic dv;
        n = fb.size();
        model_frame(pre, odd, er_pos);
        for (int i = 0; i < pre; i++) drive(2'b01, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = fb[i];
            for (int j = 0; j < 4; j++) begin
                dv = !(toggle && i >= n - 2 && (j % 2 == 1));
                drive(b[2*j +: 2], dv, (4 * i + j) == er_pos);
            end
        end
        if (odd) begin
            drive(2'($urandom), 1'b1, 1'b0);
            drive(2'($urandom), 1'b1, 1'b0);
        end
        repeat (4) drive(2'b00, 1'b0, 1'b0);
        drain(name);
    endtask

    task automatic fill_ramp(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk_rmii) begin
        exp_t e;
        bit mis;
        if (rst_ni && rx_valid) begin
            strobe_no++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected strobe #%0d: got data=%h sop=%b eop=%b expected no strobe",
                         strobe_no, rx_data, rx_sop, rx_eop);
            end else begin
                e = exp_q.pop_front();
                mis = (rx_data !== e.data) || (rx_sop !== e.sop) || (rx_eop !== e.eop);
                if (e.eop) begin
                    mis = mis || (rx_err !== e.err) || (rx_len !== 11'(e.len));
`ifdef RMII_RX_FCS_CHECK_EN
                    mis = mis || (fcs_err !== e.fcs);
`endif
                end
                if (mis) begin
                    bad++;
                    $display("FAIL strobe #%0d: got data=%h sop=%b eop=%b err=%b len=%0d expected data=%h sop=%b eop=%b err=%b len=%0d",
                             strobe_no, rx_data, rx_sop, rx_eop, rx_err, rx_len,
                             e.data, e.sop, e.eop, e.err, e.len);
                end
            end
        end
    end

    initial begin
        int n, er_pos, pre;
        bit odd, tog;

        repeat (3) @(posedge clk_rmii);
        @(negedge clk_rmii);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_sop", rx_sop, 0);
        check("reset rx_eop", rx_eop, 0);
        check("reset rx_err", rx_err, 0);
        check("reset rx_len", rx_len, 0);
        check("reset rx_data", rx_data, 0);
        check("reset frame_cnt", frame_cnt, 0);
        check("reset err_cnt", err_cnt, 0);
        rst_ni = 1'b1;

        fill_ramp(60); append_fcs();
        send_frame("good64", 28, 1'b0, -1, 1'b0);

        fill_ramp(60); append_fcs();
        send_frame("crs_toggle", 28, 1'b0, -1, 1'b1);

        fill_ramp(60); append_fcs();
        send_frame("rx_er", 28, 1'b0, 4 * 30 + 1, 1'b0);

        fill_ramp(60); append_fcs();
        send_frame("short_pre", 2, 1'b0, -1, 1'b0);
        fill_ramp(60); append_fcs();
        send_frame("after_short", 8, 1'b0, -1, 1'b0);

        fb.delete();
        send_frame("zero_len", 6, 1'b0, -1, 1'b0);

        fill_rand(20); append_fcs();
        send_frame("odd_nibble", 6, 1'b1, -1, 1'b0);

        fill_ramp(1); append_fcs();
        fb = fb[0:0];
        send_frame("one_byte", 5, 1'b0, -1, 1'b0);

        fill_ramp(60); append_fcs();
        fb[63] = 8'h00;
        send_frame("bad_fcs", 10, 1'b0, -1, 1'b0);

        fill_rand(1600);
        send_frame("overflow", 8, 1'b0, -1, 1'b0);

        fill_rand(MAX_FRAME - 4); append_fcs();
        send_frame("max_len", 5, 1'b0, -1, 1'b0);

        for (int t = 0; t < 12; t++) begin
            pre = $urandom_range(2, 9);
            n   = $urandom_range(0, 40);
            fill_rand(n);
            if (n > 0 && ($urandom % 2 == 0)) append_fcs();
            n = fb.size();
            odd = ($urandom % 5 == 0);
            er_pos = (n > 0 && ($urandom % 4 == 0)) ? $urandom_range(0, 4 * n - 1) : -1;
            tog = (n >= 2) && ($urandom % 3 == 0);
            send_frame($sformatf("rand%0d", t), pre, odd, er_pos, tog);
        end

        // Reset in the middle of a frame: outputs drop at once and nothing is emitted.
        for (int i = 0; i < 6; i++) drive(2'b01, 1'b1, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) drive(2'($urandom), 1'b1, 1'b0);
        #5;
        rst_ni = 1'b0;
        #1;
        check("midreset rx_valid", rx_valid, 0);
        check("midreset rx_eop", rx_eop, 0);
        check("midreset frame_cnt", frame_cnt, 0);
        check("midreset err_cnt", err_cnt, 0);
        exp_frames = 0;
        exp_errs = 0;
        repeat (2) drive(2'b00, 1'b0, 1'b0);
        rst_ni = 1'b1;
        repeat (2) drive(2'b00, 1'b0, 1'b0);

        fill_rand(30); append_fcs();
        send_frame("after_reset", 7, 1'b0, -1, 1'b0);

        check("final queue empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
